// File: rtl/button_pulse_gen.sv
// Button conditioner: per-channel 2-flop sync, debounce, press/auto-repeat pulse FSM,
// with a lock that suppresses all pulses while both buttons are held.

// state   | meaning
// IDLE    | button released, or press already consumed / locked out
// HOLD    | first pulse issued, waiting REPEAT_DELAY before auto-repeat
// REPEAT  | auto-repeat running, one pulse every REPEAT_RATE cycles
module button_pulse_chan #(
   parameter int CNT_W           = 16,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int REPEAT_DELAY    = 8000,
   parameter int REPEAT_RATE     = 2000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   input  logic i_lock,
   output logic o_level,
   output logic o_pulse
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] C_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] C_RR_LAST  = CNT_W'(REPEAT_RATE - 1);
   localparam logic             C_RPT_EN   = (REPEAT_DELAY > 0);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic             r_level_d;
   logic             r_pulse;
   logic [CNT_W-1:0] r_deb_cnt;
   logic [CNT_W-1:0] r_timer;
   logic [CNT_W-1:0] w_timer_nxt;
   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_req;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_deb_cnt <= '0;
      end else begin
         r_sync1   <= i_raw;
         r_sync2   <= r_sync1;
         r_level_d <= r_level;
         if (r_sync2 != r_level) begin
            if (r_deb_cnt == C_DEB_LAST) begin
               r_level   <= r_sync2;
               r_deb_cnt <= '0;
            end else begin
               r_deb_cnt <= r_deb_cnt + 1'b1;
            end
         end else begin
            r_deb_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_timer <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_pulse <= w_req;
      end
   end

   // A new press needs a level rise, so a button still held after unlock stays silent.
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_req       = 1'b0;
      if (i_lock || !r_level) begin
         w_state_nxt = ST_IDLE;
         w_timer_nxt = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!r_level_d) begin
                  w_req       = 1'b1;
                  w_timer_nxt = '0;
                  w_state_nxt = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (C_RPT_EN && (r_timer == C_RD_LAST)) begin
                  w_req       = 1'b1;
                  w_timer_nxt = '0;
                  w_state_nxt = ST_REPEAT;
               end else begin
                  w_timer_nxt = r_timer + 1'b1;
               end
            end
            ST_REPEAT: begin
               if (r_timer == C_RR_LAST) begin
                  w_req       = 1'b1;
                  w_timer_nxt = '0;
               end else begin
                  w_timer_nxt = r_timer + 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_timer_nxt = '0;
            end
         endcase
      end
   end

   assign o_level = r_level;
   assign o_pulse = r_pulse;

endmodule

module button_pulse_gen #(
   parameter int CNT_W           = 16,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int REPEAT_DELAY    = 8000,
   parameter int REPEAT_RATE     = 2000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_inc_raw,
   input  logic btn_dec_raw,
   output logic inc_pulse,
   output logic dec_pulse,
   output logic inc_level,
   output logic dec_level
);

   logic w_inc_level;
   logic w_dec_level;
   logic w_lock;

   // Both requests need both levels high, which is exactly the lock, so pulses never overlap.
   assign w_lock = w_inc_level & w_dec_level;

   button_pulse_chan #(
      .CNT_W          (CNT_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
   ) u_inc (
      .clk    (clk),
      .reset  (reset),
      .i_raw  (btn_inc_raw),
      .i_lock (w_lock),
      .o_level(w_inc_level),
      .o_pulse(inc_pulse)
   );

   button_pulse_chan #(
      .CNT_W          (CNT_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
   ) u_dec (
      .clk    (clk),
      .reset  (reset),
      .i_raw  (btn_dec_raw),
      .i_lock (w_lock),
      .o_level(w_dec_level),
      .o_pulse(dec_pulse)
   );

   assign inc_level = w_inc_level;
   assign dec_level = w_dec_level;

endmodule
